// File: rtl/writeback_pkg.sv
// Shared encodings and constants for the writeback stage and its load aligner.
package writeback_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [4:0] REGISTER_ZERO = 5'd0;

    typedef enum logic [1:0] {
        LOAD_BYTE     = 2'b00,
        LOAD_HALF     = 2'b01,
        LOAD_WORD     = 2'b10,
        LOAD_RESERVED = 2'b11
    } load_size_e;

endpackage

// File: rtl/writeback_load_data_aligner.sv
// Extracts the addressed byte/half from a raw memory word, extends it, and flags misaligned accesses.
module load_data_aligner
    import writeback_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            offset,
    input  load_size_e            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        byte_sel  = data[{offset, 3'b000} +: 8];
        half_sel  = offset[1] ? data[31:16] : data[15:0];
        byte_sign = ~is_unsigned & byte_sel[7];
        half_sign = ~is_unsigned & half_sel[15];
        value      = data;
        misaligned = 1'b0;
        case (size)
            LOAD_BYTE: value = {{(DATA_WIDTH-8){byte_sign}}, byte_sel};
            LOAD_HALF: begin
                value      = {{(DATA_WIDTH-16){half_sign}}, half_sel};
                misaligned = offset[0];
            end
            LOAD_WORD: misaligned = (offset != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates execute/load results and drives one registered register-file write per cycle.
module writeback_stage
    import writeback_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT       = 4,
    parameter int unsigned RETIRE_COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          execute_valid,
    output logic                          execute_ready,
    input  logic [4:0]                    execute_destination,
    input  logic [DATA_WIDTH-1:0]         execute_result,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [4:0]                    load_destination,
    input  logic [DATA_WIDTH-1:0]         load_data,
    input  logic [1:0]                    load_byte_offset,
    input  logic [1:0]                    load_size,
    input  logic                          load_unsigned,
    output logic                          register_write_enable,
    output logic [4:0]                    register_write_address,
    output logic [DATA_WIDTH-1:0]         register_write_data,
    output logic                          misaligned_load_error,
    output logic [RETIRE_COUNT_WIDTH-1:0] retired_count
);

    localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

    logic [STARVE_WIDTH-1:0] starve_cnt;
    logic                    execute_priority;
    logic [DATA_WIDTH-1:0]   load_value;
    logic                    load_misaligned;

    load_data_aligner u_aligner (
        .data        (load_data),
        .offset      (load_byte_offset),
        .size        (load_size_e'(load_size)),
        .is_unsigned (load_unsigned),
        .value       (load_value),
        .misaligned  (load_misaligned)
    );

    // Load normally wins; execute gets one grant after STARVE_LIMIT consecutive losses.
    always_comb begin
        execute_priority = (starve_cnt == STARVE_MAX);
        load_ready       = rst_n & load_valid & ~(execute_priority & execute_valid);
        execute_ready    = rst_n & execute_valid & ~load_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            register_write_enable  <= 1'b0;
            register_write_address <= '0;
            register_write_data    <= '0;
            misaligned_load_error  <= 1'b0;
            retired_count          <= '0;
            starve_cnt             <= '0;
        end else begin
            register_write_enable <= 1'b0;
            misaligned_load_error <= 1'b0;
            if (execute_ready) begin
                register_write_enable  <= (execute_destination != REGISTER_ZERO);
                register_write_address <= execute_destination;
                register_write_data    <= execute_result;
                retired_count          <= retired_count + RETIRE_COUNT_WIDTH'(1);
            end else if (load_ready) begin
                if (load_misaligned) begin
                    misaligned_load_error <= 1'b1;
                end else begin
                    register_write_enable  <= (load_destination != REGISTER_ZERO);
                    register_write_address <= load_destination;
                    register_write_data    <= load_value;
                    retired_count          <= retired_count + RETIRE_COUNT_WIDTH'(1);
                end
            end

            if (execute_ready) begin
                starve_cnt <= '0;
            end else if (execute_valid && load_ready && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + STARVE_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        execute_valid;
    logic        execute_ready;
    logic [4:0]  execute_destination;
    logic [31:0] execute_result;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_destination;
    logic [31:0] load_data;
    logic [1:0]  load_byte_offset;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        register_write_enable;
    logic [4:0]  register_write_address;
    logic [31:0] register_write_data;
    logic        misaligned_load_error;
    logic [31:0] retired_count;

    int checks;
    int errors;

    writeback_stage #(
        .STARVE_LIMIT       (4),
        .RETIRE_COUNT_WIDTH (32)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .execute_valid          (execute_valid),
        .execute_ready          (execute_ready),
        .execute_destination    (execute_destination),
        .execute_result         (execute_result),
        .load_valid             (load_valid),
        .load_ready             (load_ready),
        .load_destination       (load_destination),
        .load_data              (load_data),
        .load_byte_offset       (load_byte_offset),
        .load_size              (load_size),
        .load_unsigned          (load_unsigned),
        .register_write_enable  (register_write_enable),
        .register_write_address (register_write_address),
        .register_write_data    (register_write_data),
        .misaligned_load_error  (misaligned_load_error),
        .retired_count          (retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [4:0] dest, input logic [31:0] data,
                            input logic [1:0] off, input logic [1:0] size, input logic uns);
        load_valid       = 1'b1;
        load_destination = dest;
        load_data        = data;
        load_byte_offset = off;
        load_size        = size;
        load_unsigned    = uns;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        execute_valid = 1'b0; execute_destination = '0; execute_result = '0;
        load_valid = 1'b0; load_destination = '0; load_data = '0;
        load_byte_offset = '0; load_size = '0; load_unsigned = 1'b0;
        step(); step();
        load_valid = 1'b1; execute_valid = 1'b1;
        #1;
        checks++;
        if ({load_ready, execute_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_readies got=%b exp=00", {load_ready, execute_ready});
        end
        step();
        checks++;
        if ({register_write_enable, register_write_address, register_write_data, misaligned_load_error, retired_count} !== '0) begin
            errors++; $display("FAIL reset_outputs we=%b addr=%0d data=%h err=%b ret=%0d exp all zero",
                register_write_enable, register_write_address, register_write_data, misaligned_load_error, retired_count);
        end
        load_valid = 1'b0; execute_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_execute_only();
        execute_valid = 1'b1; execute_destination = 5'd5; execute_result = 32'hDEADBEEF;
        #1;
        checks++;
        if ({execute_ready, load_ready} !== 2'b10) begin
            errors++; $display("FAIL exec_ready got=%b exp=10", {execute_ready, load_ready});
        end
        step();
        execute_valid = 1'b0;
        checks++;
        if ({register_write_enable, register_write_address, register_write_data, retired_count} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'd1}) begin
            errors++; $display("FAIL exec_write we=%b addr=%0d data=%h ret=%0d exp 1/5/deadbeef/1",
                register_write_enable, register_write_address, register_write_data, retired_count);
        end
        step();
        checks++;
        if ({register_write_enable, register_write_address, register_write_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL exec_idle_hold we=%b addr=%0d data=%h exp 0/5/deadbeef",
                register_write_enable, register_write_address, register_write_data);
        end
    endtask

    task automatic test_load_format();
        set_load(5'd7, 32'h80FF7F01, 2'd3, 2'b00, 1'b0);
        #1;
        checks++;
        if ({load_ready, execute_ready} !== 2'b10) begin
            errors++; $display("FAIL load_ready got=%b exp=10", {load_ready, execute_ready});
        end
        step();
        checks++;
        if ({register_write_enable, register_write_address, register_write_data, retired_count} !== {1'b1, 5'd7, 32'hFFFFFF80, 32'd2}) begin
            errors++; $display("FAIL load_byte_signed we=%b addr=%0d data=%h ret=%0d exp 1/7/ffffff80/2",
                register_write_enable, register_write_address, register_write_data, retired_count);
        end
        load_unsigned = 1'b1;
        step();
        checks++;
        if ({register_write_enable, register_write_data, retired_count} !== {1'b1, 32'h00000080, 32'd3}) begin
            errors++; $display("FAIL load_byte_unsigned we=%b data=%h ret=%0d exp 1/00000080/3",
                register_write_enable, register_write_data, retired_count);
        end
        set_load(5'd8, 32'h80FF7F01, 2'd2, 2'b01, 1'b0);
        step();
        checks++;
        if ({register_write_data, retired_count} !== {32'hFFFF80FF, 32'd4}) begin
            errors++; $display("FAIL load_half_signed data=%h ret=%0d exp ffff80ff/4", register_write_data, retired_count);
        end
        set_load(5'd9, 32'h80FF7F01, 2'd1, 2'b00, 1'b0);
        step();
        checks++;
        if (register_write_data !== 32'h0000007F) begin
            errors++; $display("FAIL load_byte_off1 data=%h exp 0000007f", register_write_data);
        end
        set_load(5'd10, 32'h80FF7F01, 2'd0, 2'b10, 1'b0);
        step();
        load_valid = 1'b0;
        checks++;
        if ({register_write_enable, register_write_address, register_write_data, retired_count} !== {1'b1, 5'd10, 32'h80FF7F01, 32'd6}) begin
            errors++; $display("FAIL load_word we=%b addr=%0d data=%h ret=%0d exp 1/10/80ff7f01/6",
                register_write_enable, register_write_address, register_write_data, retired_count);
        end
    endtask

    task automatic test_misaligned();
        set_load(5'd11, 32'h12345678, 2'd1, 2'b01, 1'b0);
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL misal_ready got=%b exp=1", load_ready);
        end
        step();
        load_valid = 1'b0;
        checks++;
        if ({register_write_enable, misaligned_load_error, retired_count} !== {1'b0, 1'b1, 32'd6}) begin
            errors++; $display("FAIL misal_half we=%b err=%b ret=%0d exp 0/1/6",
                register_write_enable, misaligned_load_error, retired_count);
        end
        step();
        checks++;
        if (misaligned_load_error !== 1'b0) begin
            errors++; $display("FAIL misal_pulse err=%b exp=0", misaligned_load_error);
        end
        set_load(5'd11, 32'h12345678, 2'd2, 2'b10, 1'b0);
        step();
        checks++;
        if ({register_write_enable, misaligned_load_error, retired_count} !== {1'b0, 1'b1, 32'd6}) begin
            errors++; $display("FAIL misal_word we=%b err=%b ret=%0d exp 0/1/6",
                register_write_enable, misaligned_load_error, retired_count);
        end
        set_load(5'd11, 32'h12345678, 2'd0, 2'b11, 1'b0);
        step();
        load_valid = 1'b0;
        checks++;
        if ({register_write_enable, misaligned_load_error, retired_count} !== {1'b0, 1'b1, 32'd6}) begin
            errors++; $display("FAIL misal_reserved we=%b err=%b ret=%0d exp 0/1/6",
                register_write_enable, misaligned_load_error, retired_count);
        end
        step();
    endtask

    task automatic test_starvation();
        logic exp_exec;
        logic [4:0] exp_addr;
        execute_valid = 1'b1; execute_destination = 5'd1; execute_result = 32'h0000000E;
        set_load(5'd2, 32'h0000000A, 2'd0, 2'b10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_exec = (i == 4) || (i == 9);
            #1;
            checks++;
            if ({execute_ready, load_ready} !== {exp_exec, ~exp_exec}) begin
                errors++; $display("FAIL starve_grant_%0d got e/l=%b exp=%b", i, {execute_ready, load_ready}, {exp_exec, ~exp_exec});
            end
            exp_addr = exp_exec ? 5'd1 : 5'd2;
            step();
            checks++;
            if ({register_write_enable, register_write_address} !== {1'b1, exp_addr}) begin
                errors++; $display("FAIL starve_write_%0d we=%b addr=%0d exp 1/%0d", i, register_write_enable, register_write_address, exp_addr);
            end
        end
        execute_valid = 1'b0; load_valid = 1'b0;
        checks++;
        if (retired_count !== 32'd16) begin
            errors++; $display("FAIL starve_retired got=%0d exp=16", retired_count);
        end
        step();
    endtask

    task automatic test_x0();
        execute_valid = 1'b1; execute_destination = 5'd0; execute_result = 32'h12345678;
        #1;
        checks++;
        if (execute_ready !== 1'b1) begin
            errors++; $display("FAIL x0_ready got=%b exp=1", execute_ready);
        end
        step();
        execute_valid = 1'b0;
        checks++;
        if ({register_write_enable, misaligned_load_error, retired_count} !== {1'b0, 1'b0, 32'd17}) begin
            errors++; $display("FAIL x0_write we=%b err=%b ret=%0d exp 0/0/17",
                register_write_enable, misaligned_load_error, retired_count);
        end
        step();
    endtask

    task automatic test_reset_mid();
        set_load(5'd3, 32'hCAFEF00D, 2'd0, 2'b10, 1'b0);
        step();
        // A write is now in the output register; assert reset with a new load pending.
        set_load(5'd9, 32'h0BADCAFE, 2'd0, 2'b10, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({register_write_enable, load_ready, execute_ready} !== 3'b100) begin
            errors++; $display("FAIL rstmid_readies we/l/e=%b exp=100", {register_write_enable, load_ready, execute_ready});
        end
        step();
        checks++;
        if ({register_write_enable, register_write_address, retired_count} !== {1'b0, 5'd0, 32'd0}) begin
            errors++; $display("FAIL rstmid_clear we=%b addr=%0d ret=%0d exp 0/0/0",
                register_write_enable, register_write_address, retired_count);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_release_ready got=%b exp=1", load_ready);
        end
        step();
        load_valid = 1'b0;
        checks++;
        if ({register_write_enable, register_write_address, register_write_data, retired_count} !== {1'b1, 5'd9, 32'h0BADCAFE, 32'd1}) begin
            errors++; $display("FAIL rstmid_accept we=%b addr=%0d data=%h ret=%0d exp 1/9/0badcafe/1",
                register_write_enable, register_write_address, register_write_data, retired_count);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        #1;
        test_reset();
        test_execute_only();
        test_load_format();
        test_misaligned();
        test_starvation();
        test_x0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout sim time exceeded");
        $fatal(1);
    end

endmodule
